// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single data-memory port: the CPU load/store path and the
// debug/loader port share it round-robin; each access runs IDLE -> ACCESS -> WAIT -> ACK.
module dmem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_ack,
  output logic                     cpu_stall,
  input  logic                     dbg_req,
  input  logic                     dbg_we,
  input  logic [ADDRESS_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0]    dbg_wdata,
  output logic [DATA_WIDTH-1:0]    dbg_rdata,
  output logic                     dbg_ack,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  state_t                   state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     last_grant_q, last_grant_d;
  logic                     op_we_q, op_we_d;
  logic                     mem_en_q, mem_en_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic                     cpu_ack_q, cpu_ack_d;
  logic                     dbg_ack_q, dbg_ack_d;
  logic [DATA_WIDTH-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0]    dbg_rdata_q, dbg_rdata_d;

  logic grant_cpu;
  logic grant_dbg;

  // On a tie the CPU wins unless it was the last port served.
  assign grant_cpu = cpu_req & (~dbg_req | (last_grant_q == OWN_DBG));
  assign grant_dbg = dbg_req & ~grant_cpu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_CPU;
      last_grant_q <= OWN_DBG;
      op_we_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      dbg_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      op_we_q      <= op_we_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_ack_q    <= cpu_ack_d;
      dbg_ack_q    <= dbg_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cpu_req | dbg_req) state_d = S_ACCESS;
      S_ACCESS: state_d = S_WAIT;
      S_WAIT:   state_d = S_ACK;
      S_ACK:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed one state ahead so they line up with the state they belong to.
  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    op_we_d      = op_we_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_ack_d    = 1'b0;
    dbg_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_cpu) begin
          owner_d      = OWN_CPU;
          last_grant_d = OWN_CPU;
          op_we_d      = cpu_we;
          mem_en_d     = 1'b1;
          mem_we_d     = cpu_we;
          mem_addr_d   = cpu_addr;
          mem_wdata_d  = cpu_wdata;
        end else if (grant_dbg) begin
          owner_d      = OWN_DBG;
          last_grant_d = OWN_DBG;
          op_we_d      = dbg_we;
          mem_en_d     = 1'b1;
          mem_we_d     = dbg_we;
          mem_addr_d   = dbg_addr;
          mem_wdata_d  = dbg_wdata;
        end
      end
      S_WAIT: begin
        if (owner_q == OWN_CPU) begin
          cpu_ack_d = 1'b1;
          if (!op_we_q) cpu_rdata_d = mem_rdata;
        end else begin
          dbg_ack_d = 1'b1;
          if (!op_we_q) dbg_rdata_d = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous memory model and an ack scoreboard.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic [31:0] dbg_rdata;
  logic        dbg_ack;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_init = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          port;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory with one-cycle synchronous read.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'hDEADBEEF;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (cpu_ack || dbg_ack) begin
      check("ack_overlap", {63'd0, cpu_ack & dbg_ack}, 64'd0);
      if (sb.size() == 0) begin
        check("sb_unexpected_ack", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_port", {63'd0, dbg_ack}, {63'd0, e.port});
        check("sb_rdata", dbg_ack ? dbg_rdata : cpu_rdata, e.data);
      end
    end
  end

  task automatic do_access(input bit is_dbg, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd);
    bit done;
    done = 1'b0;
    sb.push_back('{is_dbg, exp_rd});
    if (is_dbg) begin
      dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    #1;
    if (!is_dbg) check("stall_N", {63'd0, cpu_stall}, 64'd1);
    for (int cyc = 1; cyc <= 10 && !done; cyc++) begin
      @(negedge clk); #1;
      if (cyc == 1) begin
        check("mem_en_N1", {63'd0, mem_en}, 64'd1);
        check("mem_we_N1", {63'd0, mem_we}, {63'd0, we});
        check("mem_addr_N1", {32'd0, mem_addr}, {32'd0, addr});
        if (we) check("mem_wdata_N1", {32'd0, mem_wdata}, {32'd0, wdata});
      end
      if (cyc == 2) check("mem_en_N2", {63'd0, mem_en}, 64'd0);
      if (!is_dbg && cyc < 3) check("stall_busy", {63'd0, cpu_stall}, 64'd1);
      if (is_dbg ? dbg_ack : cpu_ack) begin
        check("ack_latency", cyc, 64'd3);
        if (!is_dbg) check("stall_ack", {63'd0, cpu_stall}, 64'd0);
        done = 1'b1;
        if (is_dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
      end
    end
    if (!done) check("ack_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ci, di, en_cnt;
    bit dbg_done;

    // Reset state
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    #1;
    check("rst_mem_en", {63'd0, mem_en}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    check("rst_acks", {62'd0, cpu_ack, dbg_ack}, 64'd0);
    check("rst_cpu_rdata", {32'd0, cpu_rdata}, 64'd0);
    check("rst_dbg_rdata", {32'd0, dbg_rdata}, 64'd0);
    check("rst_stall", {63'd0, cpu_stall}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single CPU load, then debug write (dbg_rdata stays 0)
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    do_access(1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0);

    // Both requesting: last grant was DBG, so order is CPU, DBG, CPU, DBG
    sb.push_back('{1'b0, 32'hDEADBEEF});
    sb.push_back('{1'b1, 32'h12345678});
    sb.push_back('{1'b0, 32'hDEADBEEF});
    sb.push_back('{1'b1, 32'hA5A5A5A5});
    cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = '0; cpu_req = 1'b1;
    dbg_we = 1'b0; dbg_addr = 32'h20; dbg_wdata = '0; dbg_req = 1'b1;
    ci = 0; di = 0;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge clk); #1;
      if (cpu_ack) begin
        check("rr_cpu_ack_cycle", cyc, (ci == 0) ? 64'd3 : 64'd11);
        ci++;
        if (ci == 1) begin
          cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hA5A5A5A5;
        end else cpu_req = 1'b0;
      end
      if (dbg_ack) begin
        check("rr_dbg_ack_cycle", cyc, (di == 0) ? 64'd7 : 64'd15);
        di++;
        if (di == 1) begin
          dbg_we = 1'b0; dbg_addr = 32'h30;
        end else dbg_req = 1'b0;
      end
    end
    check("rr_cpu_count", ci, 64'd2);
    check("rr_dbg_count", di, 64'd2);
    check("rr_sb_empty", sb.size(), 64'd0);

    // Reset during WAIT of a CPU load: no ack, outputs cleared at once
    cpu_we = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_mem_en", {63'd0, mem_en}, 64'd0);
    check("midrst_mem_addr", {32'd0, mem_addr}, 64'd0);
    check("midrst_cpu_ack", {63'd0, cpu_ack}, 64'd0);
    check("midrst_cpu_rdata", {32'd0, cpu_rdata}, 64'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    check("midrst_cpu_ack_hold", {63'd0, cpu_ack}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);

    // Tie after a CPU grant goes to DBG; CPU drops its request and is never serviced
    sb.push_back('{1'b1, 32'hDEADBEEF});
    cpu_we = 1'b0; cpu_addr = 32'h20; cpu_req = 1'b1;
    dbg_we = 1'b0; dbg_addr = 32'h10; dbg_req = 1'b1;
    @(negedge clk); #1;
    check("drop_grant_addr", {32'd0, mem_addr}, 64'h10);
    check("drop_grant_en", {63'd0, mem_en}, 64'd1);
    cpu_req = 1'b0;
    en_cnt = 0;
    dbg_done = 1'b0;
    for (int cyc = 2; cyc <= 12; cyc++) begin
      @(negedge clk); #1;
      if (mem_en) en_cnt++;
      if (dbg_ack) begin
        check("drop_dbg_ack_cycle", cyc, 64'd3);
        dbg_done = 1'b1;
        dbg_req = 1'b0;
      end
    end
    check("drop_dbg_done", {63'd0, dbg_done}, 64'd1);
    check("drop_no_access", en_cnt, 64'd0);
    check("final_sb_empty", sb.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
